// File: rtl/sample_pacer_pkg.sv
// Shared types and helpers for the sample pacer and its FIFO.
package pacer_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        HOLDOFF = 1'b1
    } state_t;

    // Occupancy needs one extra bit so a full FIFO (level == DEPTH) is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_pacer_sc_fifo.sv
// Single-clock register FIFO with a combinational head read.
// The caller qualifies push/pop against level; no internal full/empty guard.
module sc_fifo
    import pacer_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           srst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [DW-1:0]                  wdata,
    output logic [DW-1:0]                  rdata,
    output logic [level_width(DEPTH)-1:0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage carries no reset; stale entries are never read because level gates pops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; level is the only full/empty source.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/sample_pacer.sv
// Rate adapter: buffers bursty upstream samples and replays them as
// single-cycle strobes spaced at least GAP clocks apart.
//
// state   | meaning
// IDLE    | holdoff expired; pop and strobe as soon as the FIFO is non-empty
// HOLDOFF | counting down gap_cnt after a strobe; no pops
module sample_pacer
    import pacer_pkg::*;
#(
    parameter int DW           = 16,
    parameter int DEPTH        = 8,
    parameter int GAP          = 513,
    parameter bit DROP_ON_FULL = 1'b0
) (
    input  logic                           clk_i,
    input  logic                           srst_i,
    input  logic                           in_valid_i,
    input  logic [DW-1:0]                  in_data_i,
    output logic                           in_ready_o,
    output logic                           sample_valid_o,
    output logic [DW-1:0]                  data_o,
    output logic [level_width(DEPTH)-1:0]  level_o,
    output logic                           overflow_o,
    input  logic                           ovf_clr_i
);

    localparam int LW = level_width(DEPTH);
    localparam int GW = $clog2(GAP) + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP - 1);

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic [DW-1:0] head;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    // Full/ready come from the registered level only; a same-cycle pop does not free a slot.
    assign full       = (level_o == FULL_LEVEL);
    assign push       = in_valid_i && !full;
    assign pop        = (state == IDLE) && (level_o != '0);
    assign drop       = DROP_ON_FULL && in_valid_i && full;
    assign in_ready_o = DROP_ON_FULL ? 1'b1 : !full;

    sc_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .srst  (srst_i),
        .push  (push),
        .pop   (pop),
        .wdata (in_data_i),
        .rdata (head),
        .level (level_o)
    );

    // Pacing FSM: pop + registered strobe, then hold off for GAP-1 cycles.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state          <= IDLE;
            gap_cnt        <= '0;
            sample_valid_o <= 1'b0;
            data_o         <= '0;
        end else begin
            sample_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        data_o         <= head;
                        sample_valid_o <= 1'b1;
                        if (GAP > 1) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= HOLDOFF;
                        end
                    end
                end
                HOLDOFF: begin
                    gap_cnt <= gap_cnt - GW'(1);
                    if (gap_cnt == GW'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky drop flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end else if (ovf_clr_i) begin
            overflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sample_pacer.sv
// Directed bench for sample_pacer: backpressure, drop-mode and long-GAP instances.
module tb_sample_pacer;

    typedef struct {
        int          cyc;
        logic [15:0] d;
    } strobe_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: DEPTH=4, GAP=4, backpressure
    logic        srst_a, v_a, rdy_a, sv_a, ovf_a, clr_a;
    logic [15:0] d_a, do_a;
    logic [2:0]  lvl_a;
    // Instance B: DEPTH=4, GAP=4, drop on full
    logic        srst_b, v_b, rdy_b, sv_b, ovf_b, clr_b;
    logic [15:0] d_b, do_b;
    logic [2:0]  lvl_b;
    // Instance C: DEPTH=8, GAP=513
    logic        srst_c, v_c, rdy_c, sv_c, ovf_c, clr_c;
    logic [15:0] d_c, do_c;
    logic [3:0]  lvl_c;

    sample_pacer #(.DW(16), .DEPTH(4), .GAP(4), .DROP_ON_FULL(1'b0)) dut_a (
        .clk_i(clk), .srst_i(srst_a), .in_valid_i(v_a), .in_data_i(d_a),
        .in_ready_o(rdy_a), .sample_valid_o(sv_a), .data_o(do_a),
        .level_o(lvl_a), .overflow_o(ovf_a), .ovf_clr_i(clr_a));

    sample_pacer #(.DW(16), .DEPTH(4), .GAP(4), .DROP_ON_FULL(1'b1)) dut_b (
        .clk_i(clk), .srst_i(srst_b), .in_valid_i(v_b), .in_data_i(d_b),
        .in_ready_o(rdy_b), .sample_valid_o(sv_b), .data_o(do_b),
        .level_o(lvl_b), .overflow_o(ovf_b), .ovf_clr_i(clr_b));

    sample_pacer #(.DW(16), .DEPTH(8), .GAP(513), .DROP_ON_FULL(1'b0)) dut_c (
        .clk_i(clk), .srst_i(srst_c), .in_valid_i(v_c), .in_data_i(d_c),
        .in_ready_o(rdy_c), .sample_valid_o(sv_c), .data_o(do_c),
        .level_o(lvl_c), .overflow_o(ovf_c), .ovf_clr_i(clr_c));

    strobe_t qa[$];
    strobe_t qb[$];
    strobe_t qc[$];

    // Strobe capture mid-cycle, tagged with the cycle number.
    always @(negedge clk) begin
        if (sv_a) qa.push_back('{cyc, do_a});
        if (sv_b) qb.push_back('{cyc, do_b});
        if (sv_c) qc.push_back('{cyc, do_c});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int t0;
        int nxt;
        bit saw_stall;
        logic [15:0] acc[$];

        srst_a = 1; v_a = 0; d_a = '0; clr_a = 0;
        srst_b = 1; v_b = 0; d_b = '0; clr_b = 0;
        srst_c = 1; v_c = 0; d_c = '0; clr_c = 0;
        tick(); tick(); tick();

        check("rst_sv",    32'(sv_a),   32'h0);
        check("rst_data",  32'(do_a),   32'h0);
        check("rst_level", 32'(lvl_a),  32'h0);
        check("rst_ready", 32'(rdy_a),  32'h1);
        check("rst_ovf",   32'(ovf_b),  32'h0);
        srst_a = 0; srst_b = 0; srst_c = 0;

        // 1. single sample
        qa.delete();
        t0 = cyc;
        wait_until(t0 + 10);
        v_a = 1; d_a = 16'h1234;
        tick();
        v_a = 0;
        check("t1_level11", 32'(lvl_a), 32'h1);
        check("t1_sv11",    32'(sv_a),  32'h0);
        tick();
        check("t1_sv12",    32'(sv_a),  32'h1);
        check("t1_data12",  32'(do_a),  32'h1234);
        check("t1_level12", 32'(lvl_a), 32'h0);
        tick();
        check("t1_sv13",    32'(sv_a),  32'h0);
        wait_until(t0 + 50);
        check("t1_data50",  32'(do_a),  32'h1234);
        check("t1_nstrobe", 32'(qa.size()), 32'd1);

        // 2. burst of four
        qa.delete();
        t0 = cyc;
        wait_until(t0 + 10);
        for (int i = 0; i < 4; i++) begin
            check("t2_ready", 32'(rdy_a), 32'h1);
            v_a = 1; d_a = 16'(i + 1);
            tick();
        end
        v_a = 0;
        wait_until(t0 + 30);
        check("t2_nstrobe", 32'(qa.size()), 32'd4);
        for (int i = 0; i < 4 && i < qa.size(); i++) begin
            check("t2_cyc",  32'(qa[i].cyc - t0), 32'(12 + 4 * i));
            check("t2_data", 32'(qa[i].d),        32'(i + 1));
        end
        check("t2_level_end", 32'(lvl_a), 32'h0);

        // 3. continuous valid against backpressure
        qa.delete();
        acc.delete();
        nxt = 0;
        saw_stall = 0;
        for (int i = 0; i < 40; i++) begin
            v_a = 1; d_a = 16'(nxt);
            if (rdy_a) begin
                acc.push_back(16'(nxt));
                nxt++;
            end else if (!saw_stall) begin
                saw_stall = 1;
                check("t3_stall_level", 32'(lvl_a), 32'h4);
            end
            tick();
        end
        v_a = 0;
        check("t3_saw_stall", 32'(saw_stall), 32'h1);
        repeat (40) tick();
        check("t3_nstrobe", 32'(qa.size()), 32'(acc.size()));
        for (int i = 0; i < acc.size() && i < qa.size(); i++) begin
            check("t3_data", 32'(qa[i].d), 32'(acc[i]));
            if (i > 0) check("t3_gap", 32'(qa[i].cyc - qa[i-1].cyc), 32'd4);
        end

        // 5. reset during holdoff with two samples queued
        t0 = cyc;
        wait_until(t0 + 10);
        v_a = 1; d_a = 16'h0011; tick();
        d_a = 16'h0022; tick();
        d_a = 16'h0033; tick();
        v_a = 0;
        check("t5_sv13",    32'(sv_a),  32'h0);
        tick();
        check("t5_level14", 32'(lvl_a), 32'h2);
        check("t5_data14",  32'(do_a),  32'h0011);
        srst_a = 1;
        tick();
        srst_a = 0;
        check("t5_rst_sv",    32'(sv_a),  32'h0);
        check("t5_rst_data",  32'(do_a),  32'h0);
        check("t5_rst_level", 32'(lvl_a), 32'h0);
        check("t5_rst_ready", 32'(rdy_a), 32'h1);
        v_a = 1; d_a = 16'h5555;
        tick();
        v_a = 0;
        check("t5_sv16", 32'(sv_a), 32'h0);
        tick();
        check("t5_sv17",   32'(sv_a), 32'h1);
        check("t5_data17", 32'(do_a), 32'h5555);
        repeat (10) tick();
        check("t5_level_end", 32'(lvl_a), 32'h0);

        // 4. drop mode
        qb.delete();
        t0 = cyc;
        wait_until(t0 + 10);
        for (int i = 0; i < 6; i++) begin
            check("t4_ready", 32'(rdy_b), 32'h1);
            if (i == 5) check("t4_level_full", 32'(lvl_b), 32'h4);
            v_b = 1; d_b = 16'(16'hA0 + i);
            tick();
        end
        v_b = 0;
        check("t4_ovf_set",   32'(ovf_b), 32'h1);
        check("t4_level_pop", 32'(lvl_b), 32'h3);
        repeat (30) tick();
        check("t4_nstrobe", 32'(qb.size()), 32'd5);
        for (int i = 0; i < 5 && i < qb.size(); i++)
            check("t4_data", 32'(qb[i].d), 32'(16'hA0 + i));
        check("t4_ovf_sticky", 32'(ovf_b), 32'h1);
        clr_b = 1;
        tick();
        clr_b = 0;
        check("t4_ovf_clr", 32'(ovf_b), 32'h0);
        repeat (10) tick();
        for (int i = 0; i < 5; i++) begin
            v_b = 1; d_b = 16'(16'hB0 + i);
            tick();
        end
        check("t4_ovf_before", 32'(ovf_b), 32'h0);
        check("t4_level_full2", 32'(lvl_b), 32'h4);
        v_b = 1; d_b = 16'h00B5; clr_b = 1;
        tick();
        v_b = 0; clr_b = 0;
        check("t4_ovf_set_wins", 32'(ovf_b), 32'h1);

        // 6. GAP=513, DEPTH=8, eight back-to-back samples
        qc.delete();
        t0 = cyc;
        wait_until(t0 + 10);
        for (int i = 0; i < 8; i++) begin
            check("t6_ready", 32'(rdy_c), 32'h1);
            v_c = 1; d_c = 16'(16'hC000 + i * 16'h0101);
            tick();
        end
        v_c = 0;
        wait_until(t0 + 12 + 7 * 513 + 20);
        check("t6_nstrobe", 32'(qc.size()), 32'd8);
        if (qc.size() > 0) check("t6_first_cyc", 32'(qc[0].cyc - t0), 32'd12);
        for (int i = 0; i < 8 && i < qc.size(); i++) begin
            check("t6_data", 32'(qc[i].d), 32'(16'hC000 + i * 16'h0101));
            if (i > 0) check("t6_gap", 32'(qc[i].cyc - qc[i-1].cyc), 32'd513);
        end
        check("t6_level_end", 32'(lvl_c), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sample_pacer.md
# sample_pacer

Input-side rate adapter for the block-RAM FIR. Accepts bursty samples from an upstream producer over a valid/ready handshake and buffers them in a small FIFO. Replays them as single-cycle `sample_valid_o` strobes, spaced at least `GAP` clocks apart. `GAP` is the minimum strobe spacing the FIR needs to finish one sample before it accepts the next (`LEN`+2). `data_o` is held stable between strobes.

## Interface
- `DW`, 16, sample width, in bits.
- `DEPTH`, 8, FIFO depth in samples. Must be a power of two and at least 2.
- `GAP`, 513, minimum clocks between rising strobes. Must be at least 1.
- `DROP_ON_FULL`, 0.
  - 0: backpressure through `in_ready_o`.
  - 1: `in_ready_o` is tied to 1, and samples that arrive while the FIFO is full are discarded.
- `clk_i` input 1: the single clock. All logic is on the rising edge.
- `srst_i` input 1: reset. It is synchronous and active-high.
- `in_valid_i` input 1: upstream sample valid.
- `in_data_i` input DW: upstream sample.
- `in_ready_o` output 1: the block accepts `in_data_i` this cycle.
- `sample_valid_o` output 1: one-cycle strobe to the FIR.
- `data_o` output DW: emitted sample. Held until the next strobe.
- `level_o` output $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow_o` output 1: sticky flag set when a sample is dropped. Only ever set when `DROP_ON_FULL`=1.
- `ovf_clr_i` input 1: clears `overflow_o`.

## Operation
- Push: `push` = `in_valid_i` && (`level_o` < DEPTH).
  - With `DROP_ON_FULL`=0, `in_ready_o` = (`level_o` < DEPTH), computed combinationally from registered `level_o`.
  - With `DROP_ON_FULL`=1, `in_valid_i` when `level_o`==DEPTH is a drop. A drop sets `overflow_o` on the next edge.
- Pop: `pop` = (`state`==IDLE) && (`level_o` != 0).
- FSM states:
  - IDLE: holdoff has expired. If the FIFO is non-empty, pop, register the head into `data_o`, assert `sample_valid_o` on the next cycle, load `gap_cnt` <= GAP-1 and go to HOLDOFF. If GAP==1, stay in IDLE instead.
  - HOLDOFF: `gap_cnt` decrements by 1 each cycle. Go to IDLE on the cycle `gap_cnt` reaches 1, i.e. GAP-1 cycles after the pop.
- Level update:
  - Simultaneous push and pop leave `level_o` unchanged.
  - A push into a full FIFO is never accepted, even if a pop happens in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `level_o` is the only full/empty source.
- `overflow_o`:
  - Set has priority over `ovf_clr_i` in the same cycle.
  - `ovf_clr_i` alone clears it on the next edge.
- No arithmetic is performed on the data; samples pass bit-exact.

## Timing
- Reset values: `sample_valid_o`=0, `data_o`=0, `level_o`=0, `overflow_o`=0, `in_ready_o`=1, state IDLE, `gap_cnt`=0, both pointers 0.
- Latency: a sample pushed at edge t into an empty FIFO with the FSM in IDLE gives `sample_valid_o`=1 and `data_o`=sample in cycle t+2. There is one cycle for FIFO registration and one for the output register.
- Back-to-back strobes are exactly GAP cycles apart while the FIFO stays non-empty. They are never closer than GAP.
- `sample_valid_o` is never high for two consecutive cycles unless GAP==1.
- `data_o` changes only in the cycle where `sample_valid_o` rises.
- Reset mid-operation:
  - FIFO contents and any holdoff in progress are discarded.
  - The first post-reset sample can strobe 2 cycles after it is pushed.
  - The FIR shares `srst_i`, so both blocks restart together.
- `in_ready_o` reflects occupancy from the previous edge only. It does not look ahead to a same-cycle pop.

## Structure
- `pacer_pkg` holds the `state_t` enum (IDLE, HOLDOFF) and a function computing `level_o` width from DEPTH.
- One sub-module, `sc_fifo`: synchronous single-clock FIFO with parameters DW and DEPTH, and ports push, pop, wdata, rdata, level.
  - Register-based storage with combinational read of the head.
- `sample_pacer` holds the FSM, `gap_cnt` ($clog2(GAP)+1 bits), the output register and overflow logic.

## Test plan
Bench configuration: DW=16, DEPTH=4, GAP=4 unless stated otherwise.
1. Single sample: push 0x1234 at cycle 10.
   - `sample_valid_o` high only in cycle 12, with `data_o`=0x1234.
   - `data_o` is still 0x1234 at cycle 50.
   - `level_o` returns to 0.
2. Burst: push 0x0001–0x0004 on cycles 10–13.
   - Strobes in cycles 12, 16, 20, 24, carrying 0x0001, 0x0002, 0x0003, 0x0004 in that order.
   - `in_ready_o` stays 1, because the level peaks at 3.
3. Backpressure (`DROP_ON_FULL`=0): hold `in_valid_i`=1 continuously with incrementing data from 0x0000.
   - `in_ready_o` drops once `level_o`=4.
   - Every accepted value is strobed exactly once, in order, with no gaps in the sequence.
4. Drop mode (`DROP_ON_FULL`=1): push 6 samples back-to-back, 0xA0–0xA5.
   - `overflow_o`=1 after the push that hits a full FIFO.
   - The strobed sequence has no duplicates and contains exactly the accepted samples.
   - Pulsing `ovf_clr_i` clears `overflow_o` on the next edge.
   - A drop coincident with `ovf_clr_i` leaves `overflow_o` at 1.
5. Reset mid-holdoff: assert `srst_i` for 1 cycle, 2 cycles after a strobe, while `level_o`=2.
   - All outputs return to reset values.
   - A push of 0x5555 right after reset strobes 2 cycles later, with no leftover GAP delay.
6. GAP=513, DEPTH=8: drive a 511-tap FIR with 8 back-to-back samples.
   - Strobes are exactly 513 cycles apart.
   - The FIR output matches the golden model for every sample.
